rob_commit_unit: RTL
====================

Name: rob_commit_unit

Overview:
In-order reorder buffer and retirement block for the out-of-order core. It allocates one ROB entry per renamed instruction and returns its 5-bit rob tag. It collects completion reports from the ALU, memory and branch functional units, and retires the oldest completed instruction each cycle. Retirement hands pd_old back to the free list; a branch mispredict squashes every entry younger than the branch.

Parameters:
DEPTH, 32, number of ROB entries; power of two; tag width is log2(DEPTH) = 5.
PREG_W, 7, physical register index width.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
alloc_valid  in  1  rename stage presents an instruction.
alloc_pd_new  in  7  newly mapped destination preg.
alloc_pd_old  in  7  previous mapping of the destination arch reg.
alloc_pc  in  32  instruction PC.
alloc_ready  out  1  entry available (combinational: count < DEPTH and no flush this cycle).
alloc_tag  out  5  tag granted to the presented instruction (= tail).
alu_done  in  1  ALU completion strobe.
alu_tag  in  5  ROB tag of the completing ALU op.
mem_done  in  1  memory unit completion strobe.
mem_tag  in  5  ROB tag of the completing memory op.
b_done  in  1  branch unit completion strobe.
b_tag  in  5  ROB tag of the completing branch/jump.
mispredict  in  1  branch unit reports a mispredict (qualified by b_done).
mispredict_tag  in  5  tag of the mispredicted branch.
commit_valid  out  1  registered; one instruction retired this cycle.
commit_tag  out  5  registered; tag of the retired entry.
commit_pd_new  out  7  registered; retired destination preg.
commit_pd_old  out  7  registered; preg to return to the free list.
commit_pc  out  32  registered; PC of the retired instruction.
flush  out  1  registered one-cycle pulse; younger instructions squashed.
rob_empty  out  1  count == 0.
rob_count  out  6  occupied entries, 0..32.

Behaviour:
- Storage: per entry valid, complete, pd_new, pd_old, pc. Pointers head and tail are 5-bit and wrap modulo 32. count is a 6-bit register.
- Reset (async, rstn low):
  - all valid and complete bits = 0; head = tail = count = 0.
  - commit_* outputs = 0; flush = 0; alloc_ready = 1; rob_empty = 1.
- Allocate: on alloc_valid && alloc_ready, write the entry at tail with valid=1 and complete=0, then tail++. alloc_tag is visible in the same cycle.
- Complete: each of alu_done, mem_done and b_done sets complete on its tagged entry if that entry is valid.
  - All three may fire in the same cycle.
  - A strobe to an invalid entry is ignored.
- Commit: at most one per cycle. If entry[head] is valid && complete at the clock edge, the next cycle shows commit_valid=1 with that entry's fields. The entry is then cleared and head++. Commit latency from a completion strobe is at least 1 cycle; a completion in the same cycle as the head check does not commit until the following edge.
- Mispredict (b_done && mispredict):
  - Entries from mispredict_tag+1 through tail-1 are invalidated.
  - tail becomes mispredict_tag+1 and count is recomputed as ((mispredict_tag - head) mod 32) + 1, minus 1 if the head commits this cycle.
  - The branch entry itself is kept and marked complete.
  - flush pulses the next cycle.
  - Any allocation in the mispredict cycle is dropped; alloc_ready is forced low.
  - Same-cycle completions to squashed entries are discarded.
- Simultaneous allocate and commit: count is unchanged; full and empty are evaluated on the pre-edge count.
- Full (count = 32): alloc_ready = 0; head == tail is disambiguated by count.
- Flush when head is the mispredicted branch and it commits the same cycle: count becomes 0 and head = tail.
- Reset asserted mid-operation discards all state immediately; commit_valid and flush drop asynchronously.

Test Plan:
- Allocate 3 entries (PCs 0x100, 0x104, 0x108), then complete tags 2, 1, 0 out of order -> commits occur in order 0, 1, 2 on consecutive cycles; commit_pd_old matches each entry; rob_empty=1 afterward.
- Allocate 32 entries without completion -> alloc_ready=0 and rob_count=32. Complete tag 0 -> one commit; alloc_ready=1 the next cycle; a new allocation receives tag 0 (wrap).
- Allocate tags 0..5, then mispredict with tag 2 -> flush=1 for one cycle; tail=3; rob_count=3. Completions to tag 4 are ignored; the next alloc_tag = 3.
- alu_done, mem_done and b_done hit tags 0, 1 and 2 in the same cycle -> all three are marked complete; three commits follow on successive cycles.
- With head=31 and tail=1, allocate and commit in the same cycle -> rob_count unchanged; head wraps to 0; tail = 2.
- Pulse rstn low during an active commit -> commit_valid=0 immediately; rob_count=0; after release, the first alloc_tag = 0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit
// In-order reorder buffer with single-instruction retirement.
// The block hands one ROB tag to each renamed instruction. It marks entries
// complete from three functional-unit strobes and retires the oldest entry
// once that entry is complete. A branch mispredict squashes every entry
// younger than the branch.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   alloc_valid/pd_new/pd_old/pc    rename-stage allocation request
//   alloc_ready, alloc_tag          combinational grant and tag (= tail)
//   alu_/mem_/b_done + *_tag        completion strobes
//   mispredict, mispredict_tag      branch mispredict, qualified by b_done
//   commit_valid/tag/pd_new/pd_old/pc   registered retirement report
//   flush                           registered one-cycle squash pulse
//   rob_empty, rob_count            occupancy status
module rob_commit_unit #(
    parameter int DEPTH  = 32,
    parameter int PREG_W = 7,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int CNT_W = TAG_W + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              alloc_valid,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    input  logic [31:0]       alloc_pc,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              alu_done,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic              mem_done,
    input  logic [TAG_W-1:0]  mem_tag,
    input  logic              b_done,
    input  logic [TAG_W-1:0]  b_tag,
    input  logic              mispredict,
    input  logic [TAG_W-1:0]  mispredict_tag,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [PREG_W-1:0] commit_pd_old,
    output logic [31:0]       commit_pc,
    output logic              flush,
    output logic              rob_empty,
    output logic [CNT_W-1:0]  rob_count
);

    localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] TAG_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  complete_r;
    logic [PREG_W-1:0] pd_new_r [DEPTH];
    logic [PREG_W-1:0] pd_old_r [DEPTH];
    logic [31:0]       pc_r     [DEPTH];
    logic [TAG_W-1:0]  head_r;
    logic [TAG_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              commit_valid_r;
    logic [TAG_W-1:0]  commit_tag_r;
    logic [PREG_W-1:0] commit_pd_new_r;
    logic [PREG_W-1:0] commit_pd_old_r;
    logic [31:0]       commit_pc_r;
    logic              flush_r;

    logic              head_commit_s;
    logic              flush_s;
    logic              alloc_ready_s;
    logic              alloc_fire_s;
    logic [TAG_W-1:0]  off_m_s;
    logic [CNT_W-1:0]  flush_count_s;
    logic [DEPTH-1:0]  done_mask_s;
    logic [DEPTH-1:0]  alloc_mask_s;
    logic [DEPTH-1:0]  commit_mask_s;
    logic [DEPTH-1:0]  squash_mask_s;
    logic [DEPTH-1:0]  branch_mask_s;
    logic [DEPTH-1:0]  valid_nxt_s;
    logic [DEPTH-1:0]  complete_nxt_s;

    // Control decode: retire, mispredict and allocation qualification.
    always_comb begin
        head_commit_s = valid_r[head_r] & complete_r[head_r];
        // A mispredict naming an unoccupied slot has no branch to anchor to.
        flush_s       = b_done & mispredict & valid_r[mispredict_tag];
        alloc_ready_s = (count_r != CNT_FULL) & ~flush_s;
        alloc_fire_s  = alloc_valid & alloc_ready_s;
        // Age of the branch relative to head; survivors are ages 0..off_m_s.
        off_m_s       = mispredict_tag - head_r;
        flush_count_s = {1'b0, off_m_s} + CNT_ONE - CNT_W'(head_commit_s);
    end

    // Per-entry valid/complete next state built from one-hot event masks.
    always_comb begin
        logic [TAG_W-1:0] off_i_v;
        done_mask_s   = ((alu_done ? (ONE_HOT0 << alu_tag) : {DEPTH{1'b0}}) |
                         (mem_done ? (ONE_HOT0 << mem_tag) : {DEPTH{1'b0}}) |
                         (b_done   ? (ONE_HOT0 << b_tag)   : {DEPTH{1'b0}})) & valid_r;
        alloc_mask_s  = alloc_fire_s  ? (ONE_HOT0 << tail_r)         : {DEPTH{1'b0}};
        commit_mask_s = head_commit_s ? (ONE_HOT0 << head_r)         : {DEPTH{1'b0}};
        branch_mask_s = flush_s       ? (ONE_HOT0 << mispredict_tag) : {DEPTH{1'b0}};
        squash_mask_s = {DEPTH{1'b0}};
        off_i_v       = {TAG_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_i_v          = TAG_W'(i) - head_r;
            squash_mask_s[i] = flush_s & (off_i_v > off_m_s);
        end
        // Squash and retire clear last, so late completions to dead slots are lost.
        valid_nxt_s    = (valid_r | alloc_mask_s) & ~commit_mask_s & ~squash_mask_s;
        complete_nxt_s = (complete_r | done_mask_s | branch_mask_s)
                         & ~alloc_mask_s & ~commit_mask_s & ~squash_mask_s;
    end

    // Pointer, occupancy and status-bit registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r    <= {DEPTH{1'b0}};
            complete_r <= {DEPTH{1'b0}};
            head_r     <= {TAG_W{1'b0}};
            tail_r     <= {TAG_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            valid_r    <= valid_nxt_s;
            complete_r <= complete_nxt_s;
            head_r     <= head_commit_s ? (head_r + TAG_ONE) : head_r;
            if (flush_s) begin
                tail_r  <= mispredict_tag + TAG_ONE;
                count_r <= flush_count_s;
            end else begin
                tail_r  <= alloc_fire_s ? (tail_r + TAG_ONE) : tail_r;
                count_r <= count_r + CNT_W'(alloc_fire_s) - CNT_W'(head_commit_s);
            end
        end
    end

    // Entry payload storage, written at tail on allocation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pd_new_r[i] <= {PREG_W{1'b0}};
                pd_old_r[i] <= {PREG_W{1'b0}};
                pc_r[i]     <= 32'h0000_0000;
            end
        end else if (alloc_fire_s) begin
            pd_new_r[tail_r] <= alloc_pd_new;
            pd_old_r[tail_r] <= alloc_pd_old;
            pc_r[tail_r]     <= alloc_pc;
        end
    end

    // Registered retirement report and flush pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            commit_valid_r  <= 1'b0;
            commit_tag_r    <= {TAG_W{1'b0}};
            commit_pd_new_r <= {PREG_W{1'b0}};
            commit_pd_old_r <= {PREG_W{1'b0}};
            commit_pc_r     <= 32'h0000_0000;
            flush_r         <= 1'b0;
        end else begin
            flush_r        <= flush_s;
            commit_valid_r <= head_commit_s;
            if (head_commit_s) begin
                commit_tag_r    <= head_r;
                commit_pd_new_r <= pd_new_r[head_r];
                commit_pd_old_r <= pd_old_r[head_r];
                commit_pc_r     <= pc_r[head_r];
            end else begin
                commit_tag_r    <= {TAG_W{1'b0}};
                commit_pd_new_r <= {PREG_W{1'b0}};
                commit_pd_old_r <= {PREG_W{1'b0}};
                commit_pc_r     <= 32'h0000_0000;
            end
        end
    end

    assign alloc_ready   = alloc_ready_s;
    assign alloc_tag     = tail_r;
    assign commit_valid  = commit_valid_r;
    assign commit_tag    = commit_tag_r;
    assign commit_pd_new = commit_pd_new_r;
    assign commit_pd_old = commit_pd_old_r;
    assign commit_pc     = commit_pc_r;
    assign flush         = flush_r;
    assign rob_empty     = (count_r == {CNT_W{1'b0}});
    assign rob_count     = count_r;

endmodule
